game_state_ctrl: RTL
====================

// Module: game_state_ctrl
// PURPOSE
// - Game sequencer driving the 2-bit `state` bus into Display:
//   0 = READY, 1 = PLAY, 2 = DEAD (GG prompt), 3 = PAUSE.
// - Debounces the flap and pause buttons, and reacts to isDead from the bird controller.
// - Enforces a post-death hold-off before a restart is accepted.
// - Tracks the best score across rounds.
// PARAMETERS
// - DEB_CYCLES  1_000_000   clk cycles a raw button level must be stable before it is accepted (10 ms @100 MHz)
// - DEAD_HOLD   50_000_000  clk cycles after entering DEAD during which flap presses are ignored
// - SCORE_W     8           width of score / best_score
// PORTS
// - clk          in   1        system clock; all logic on posedge
// - rst          in   1        synchronous, active-high reset
// - up_btn_raw   in   1        raw flap/start button, asynchronous
// - pause_btn_raw in  1        raw pause button, asynchronous
// - is_dead      in   1        collision flag from Bird_Ctrl, level
// - score        in   SCORE_W  current round score from Pipe_Generator
// - state        out  2        game state to Display / Bird_Ctrl / Pipe_Generator
// - round_start  out  1        1-cycle pulse on READY->PLAY
// - best_score   out  SCORE_W  highest score seen since reset
// - new_best     out  1        high while in DEAD if this round set a new best
// BEHAVIOUR
// - Reset: state = READY, round_start = 0, best_score = 0, new_best = 0, hold counter = 0.
//   Debouncers reset to a released (0) stable level.
// - Buttons:
//   - 2-flop synchronizer, then debounce.
//   - Debounced level changes only after DEB_CYCLES consecutive equal samples.
//   - Press event = 1-cycle pulse on the debounced 0->1 edge.
//   - Latency from raw edge to pulse: 2 + DEB_CYCLES cycles.
//   - Glitches shorter than DEB_CYCLES produce no pulse.
// - FSM, one transition per cycle. Priority within a state is top to bottom:
//   - READY: up press -> PLAY, asserting round_start in the same cycle as the state change.
//     pause press and is_dead are ignored.
//   - PLAY: is_dead = 1 -> DEAD. Death has priority over a simultaneous pause press.
//     Otherwise pause press -> PAUSE. up presses are ignored here; Bird_Ctrl samples the button itself.
//   - PAUSE: pause press -> PLAY. is_dead and up are ignored.
//   - DEAD: hold counter loads DEAD_HOLD-1 on entry and counts down to 0.
//     An up press while counter != 0 is dropped and not queued.
//     An up press with counter == 0 -> READY.
// - Best score:
//   - On the PLAY->DEAD cycle, if score > best_score: best_score <= score and new_best <= 1.
//   - Equal scores are not a new best.
//   - new_best clears on leaving DEAD.
//   - Unsigned compare at SCORE_W bits; no wrap handling. Score saturation is Pipe_Generator's responsibility.
// - Outputs are registered. state changes the cycle after the qualifying event is sampled.
// - rst mid-round forces READY in the next cycle regardless of state. best_score is cleared too.
// - The FSM never holds an illegal encoding; all 4 codes are used.
// STRUCTURE
// - game_defs.vh holds the shared state localparams:
//   ST_READY = 2'd0, ST_PLAY = 2'd1, ST_DEAD = 2'd2, ST_PAUSE = 2'd3.
//   Display, Bird_Ctrl and Pipe_Generator include the same header.
// - Sub-module btn_debounce (parameter DEB_CYCLES; ports clk, rst, raw, level, press) holds the synchronizer,
//   stability counter and edge pulse. It is instantiated twice.
// - Top level holds the FSM, the DEAD hold counter (width $clog2(DEAD_HOLD)) and the best-score register.
// TESTING (DEB_CYCLES = 4, DEAD_HOLD = 8 overrides)
// - Reset/idle: rst 2 cycles -> state = 0, best_score = 0, round_start = 0.
//   10 idle cycles leave all outputs unchanged.
// - Debounce:
//   - up_btn_raw high 3 cycles then low -> no transition.
//   - up_btn_raw held 10 cycles -> state 0->1 exactly 6 cycles after the raw edge.
//   - round_start is high for exactly 1 cycle.
// - Pause vs death:
//   - In PLAY, pause press -> state 3; is_dead = 1 while paused -> stays 3.
//   - Second pause press -> 1.
//   - is_dead = 1 on the same cycle as a pause press -> state 2.
// - Best score:
//   - Die with score = 5 -> best_score = 5, new_best = 1.
//   - Next round die with score = 5 -> best stays 5, new_best = 0.
//   - Next round die with score = 9 -> best = 9, new_best = 1.
// - Hold-off:
//   - In DEAD, up press whose pulse lands at hold-count 3 -> ignored, state = 2.
//   - Press after count reaches 0 -> state = 0, new_best = 0.
// - Reset mid-operation: rst asserted in PAUSE with best = 9 -> next cycle state = 0, best_score = 0.

Source files
------------

// File: rtl/game_state_ctrl_pkg.sv
// Shared game-state encoding and sizing helpers for the game sequencer.
package game_state_ctrl_pkg;

  // Encoding is shared with Display, Bird_Ctrl and Pipe_Generator; all 4 codes are used.
  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DEAD  = 2'd2,
    ST_PAUSE = 2'd3
  } game_state_t;

  localparam int NUM_BTNS  = 2;
  localparam int BTN_UP    = 0;
  localparam int BTN_PAUSE = 1;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_state_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, rising-edge press pulse.
module btn_debounce
  import game_state_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = cnt_w(DEB_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          stable_hit;

  // The sample currently presented counts as the last of the DEB_CYCLES equal samples,
  // so the press pulse is visible in the same cycle the level is committed.
  assign stable_hit = (sync[1] != level) && (cnt == CW'(DEB_CYCLES - 1));
  assign press      = stable_hit & sync[1];

  // Synchronize the raw input and accept a new level only after a stable run.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (stable_hit) begin
        level <= sync[1];
        cnt   <= '0;
      end else if (sync[1] != level) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: READY/PLAY/DEAD/PAUSE FSM, post-death hold-off and best-score tracking.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int DEAD_HOLD  = 50_000_000,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_btn_raw,
  input  logic               pause_btn_raw,
  input  logic               is_dead,
  input  logic [SCORE_W-1:0] score,
  output logic [1:0]         state,
  output logic               round_start,
  output logic [SCORE_W-1:0] best_score,
  output logic               new_best
);

  localparam int                HW        = cnt_w(DEAD_HOLD);
  localparam logic [HW-1:0]     HOLD_INIT = HW'(DEAD_HOLD - 1);

  logic [NUM_BTNS-1:0] btn_raw, btn_level, btn_press;

  game_state_t         st_q, st_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [SCORE_W-1:0]  best_d;
  logic                new_best_d, round_start_d;

  assign btn_raw = {pause_btn_raw, up_btn_raw};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .press (btn_press[i])
    );
  end

  assign state = st_q;

  // Next-state, hold-off and best-score logic; priority within a state is top to bottom.
  always_comb begin
    st_d          = st_q;
    hold_d        = hold_q;
    best_d        = best_score;
    new_best_d    = new_best;
    round_start_d = 1'b0;
    case (st_q)
      ST_READY: begin
        if (btn_press[BTN_UP]) begin
          st_d          = ST_PLAY;
          round_start_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (is_dead) begin
          st_d   = ST_DEAD;
          hold_d = HOLD_INIT;
          if (score > best_score) begin
            best_d     = score;
            new_best_d = 1'b1;
          end else begin
            new_best_d = 1'b0;
          end
        end else if (btn_press[BTN_PAUSE]) begin
          st_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (btn_press[BTN_PAUSE]) st_d = ST_PLAY;
      end
      ST_DEAD: begin
        // Presses during the hold-off are dropped, not queued.
        if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end else if (btn_press[BTN_UP]) begin
          st_d       = ST_READY;
          new_best_d = 1'b0;
        end
      end
    endcase
  end

  // Register all FSM state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ST_READY;
      hold_q      <= '0;
      best_score  <= '0;
      new_best    <= 1'b0;
      round_start <= 1'b0;
    end else begin
      st_q        <= st_d;
      hold_q      <= hold_d;
      best_score  <= best_d;
      new_best    <= new_best_d;
      round_start <= round_start_d;
    end
  end

endmodule
